pcs_sync: RTL and testbench



---
 rtl/pcs_sync_pkg.sv | 150 +++++++++++++++
 rtl/pcs_sync_cg_classify.sv | 33 +++
 rtl/pcs_sync.sv | 130 +++++++++++++
 tb/tb_pcs_sync.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pcs_sync_pkg.sv
// Shared definitions for the PCS sync stage and receiver:
// 8b/10b code-group table, one-hot sync states, defaults.
package pcs_sync_pkg;

  localparam int GOOD_CGS_MAX_DEF = 3;

  localparam logic [9:0] K28_5_N = 10'h0FA;
  localparam logic [9:0] K28_5_P = 10'h305;

  typedef enum logic [12:0] {
    LOSS_OF_SYNC     = 13'h0001,
    COMMA_DETECT_1   = 13'h0002,
    COMMA_DETECT_2   = 13'h0004,
    COMMA_DETECT_3   = 13'h0008,
    ACQUIRE_SYNC_1   = 13'h0010,
    ACQUIRE_SYNC_2   = 13'h0020,
    SYNC_ACQUIRED_1  = 13'h0040,
    SYNC_ACQUIRED_2  = 13'h0080,
    SYNC_ACQUIRED_2A = 13'h0100,
    SYNC_ACQUIRED_3  = 13'h0200,
    SYNC_ACQUIRED_3A = 13'h0400,
    SYNC_ACQUIRED_4  = 13'h0800,
    SYNC_ACQUIRED_4A = 13'h1000
  } state_e;

  localparam logic [12:0] CD_MASK   = 13'h000E;
  localparam logic [12:0] SA_MASK   = 13'h1FC0;
  localparam logic [12:0] SAN_MASK  = 13'h0A80;
  localparam logic [12:0] SANA_MASK = 13'h1500;

  // 5b/6b table, RD- column, bits abcdei
  function automatic logic [5:0] cg_6b(
    input logic [4:0] x
  );
    case (x)
      5'd0:    return 6'b100111;
      5'd1:    return 6'b011101;
      5'd2:    return 6'b101101;
      5'd3:    return 6'b110001;
      5'd4:    return 6'b110101;
      5'd5:    return 6'b101001;
      5'd6:    return 6'b011001;
      5'd7:    return 6'b111000;
      5'd8:    return 6'b111001;
      5'd9:    return 6'b100101;
      5'd10:   return 6'b010101;
      5'd11:   return 6'b110100;
      5'd12:   return 6'b001101;
      5'd13:   return 6'b101100;
      5'd14:   return 6'b011100;
      5'd15:   return 6'b010111;
      5'd16:   return 6'b011011;
      5'd17:   return 6'b100011;
      5'd18:   return 6'b010011;
      5'd19:   return 6'b110010;
      5'd20:   return 6'b001011;
      5'd21:   return 6'b101010;
      5'd22:   return 6'b011010;
      5'd23:   return 6'b111010;
      5'd24:   return 6'b110011;
      5'd25:   return 6'b100110;
      5'd26:   return 6'b010110;
      5'd27:   return 6'b110110;
      5'd28:   return 6'b001110;
      5'd29:   return 6'b101110;
      5'd30:   return 6'b011110;
      default: return 6'b101011;
    endcase
  endfunction

  // 3b/4b data table, RD- column (P7 for y=7), bits fghj
  function automatic logic [3:0] cg_4d(
    input logic [2:0] y
  );
    case (y)
      3'd0:    return 4'b1011;
      3'd1:    return 4'b1001;
      3'd2:    return 4'b0101;
      3'd3:    return 4'b1100;
      3'd4:    return 4'b1101;
      3'd5:    return 4'b1010;
      3'd6:    return 4'b0110;
      default: return 4'b1110;
    endcase
  endfunction

  // 3b/4b control table, RD- column
  function automatic logic [3:0] cg_4k(
    input logic [2:0] y
  );
    case (y)
      3'd0:    return 4'b1011;
      3'd1:    return 4'b0110;
      3'd2:    return 4'b1010;
      3'd3:    return 4'b1100;
      3'd4:    return 4'b1101;
      3'd5:    return 4'b0101;
      3'd6:    return 4'b1001;
      default: return 4'b0111;
    endcase
  endfunction

  // Only K28.y and K23/27/29/30.7 exist
  function automatic logic cg_k_ok(
    input logic [7:0] v
  );
    logic [4:0] x;
    x = v[4:0];
    return (x == 5'd28) ||
           ((v[7:5] == 3'd7) &&
            (x == 5'd23 || x == 5'd27 ||
             x == 5'd29 || x == 5'd30));
  endfunction

  // Encode byte v (k=control) at running disparity rd (1 = RD+)
  function automatic logic [9:0] cg_enc(
    input logic [7:0] v,
    input logic       k,
    input logic       rd
  );
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd1;
    logic       alt;
    x   = v[4:0];
    y   = v[7:5];
    c6  = (k && x == 5'd28) ? 6'b001111 : cg_6b(x);
    rd1 = rd;
    if ($countones(c6) != 3) begin
      rd1 = ~rd;
      if (rd) c6 = ~c6;
    end else if (rd && x == 5'd7) begin
      c6 = ~c6;
    end
    alt = (!rd1 && (x == 5'd17 || x == 5'd18 ||
                    x == 5'd20)) ||
          (rd1 && (x == 5'd11 || x == 5'd13 ||
                   x == 5'd14));
    if (k)                    c4 = cg_4k(y);
    else if (y == 3'd7 && alt) c4 = 4'b0111;
    else                      c4 = cg_4d(y);
    if (rd1 && (k || $countones(c4) != 2 ||
                y == 3'd3))
      c4 = ~c4;
    return {c6, c4};
  endfunction

endpackage

// File: rtl/pcs_sync_cg_classify.sv
// Combinational code-group classifier: valid / data / comma.
// Shared by the sync stage and the receiver.
module pcs_cg_classify
  import pcs_sync_pkg::*;
(
  input  logic [9:0] code_group,
  output logic       is_valid,
  output logic       is_data,
  output logic       is_comma
);

  logic is_ctrl;

  // Match against every table entry in both disparities
  always_comb begin
    is_data = 1'b0;
    is_ctrl = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (cg_enc(8'(i), 1'b0, r[0]) == code_group)
          is_data = 1'b1;
        if (cg_k_ok(8'(i)) &&
            cg_enc(8'(i), 1'b1, r[0]) == code_group)
          is_ctrl = 1'b1;
      end
    end
  end

  assign is_valid = is_data | is_ctrl;
  assign is_comma = (code_group == K28_5_N) ||
                    (code_group == K28_5_P);

endmodule

// File: rtl/pcs_sync.sv
// PCS synchronization stage: acquires code-group alignment,
// forwards each group with SUDI, rx_even and sync_status.
module pcs_sync
  import pcs_sync_pkg::*;
#(
  parameter int GOOD_CGS_MAX = GOOD_CGS_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] code_group,
  output logic [9:0] x,
  output logic       SUDI,
  output logic       rx_even,
  output logic       sync_status
);

  localparam logic [1:0] GC_MAX = 2'(GOOD_CGS_MAX);

  logic       is_valid;
  logic       is_data;
  logic       is_comma;
  logic       cgbad;

  state_e     state_q, state_d;
  logic [1:0] gc_q, gc_d;
  logic [9:0] x_q;
  logic       sudi_q;
  logic       rx_even_q, rx_even_d;
  logic       sync_q, sync_d;

  pcs_cg_classify u_cls (
    .code_group (code_group),
    .is_valid   (is_valid),
    .is_data    (is_data),
    .is_comma   (is_comma)
  );

  // Odd-slot commas are misalignment, not idles
  assign cgbad = !is_valid || (is_comma && rx_even_q);

  // Next state and good_cgs from the current group
  always_comb begin
    state_d = state_q;
    gc_d    = gc_q;
    unique case (state_q)
      LOSS_OF_SYNC:
        if (is_comma) state_d = COMMA_DETECT_1;
      COMMA_DETECT_1:
        state_d = is_data ? ACQUIRE_SYNC_1
                          : LOSS_OF_SYNC;
      COMMA_DETECT_2:
        state_d = is_data ? ACQUIRE_SYNC_2
                          : LOSS_OF_SYNC;
      COMMA_DETECT_3:
        state_d = is_data ? SYNC_ACQUIRED_1
                          : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1:
        if (cgbad)
          state_d = LOSS_OF_SYNC;
        else if (is_comma && !rx_even_q)
          state_d = COMMA_DETECT_2;
      ACQUIRE_SYNC_2:
        if (cgbad)
          state_d = LOSS_OF_SYNC;
        else if (is_comma && !rx_even_q)
          state_d = COMMA_DETECT_3;
      SYNC_ACQUIRED_1:
        if (cgbad) state_d = SYNC_ACQUIRED_2;
      SYNC_ACQUIRED_2:
        state_d = cgbad ? SYNC_ACQUIRED_3
                        : SYNC_ACQUIRED_2A;
      SYNC_ACQUIRED_2A:
        if (cgbad)
          state_d = SYNC_ACQUIRED_3;
        else if (gc_q == GC_MAX)
          state_d = SYNC_ACQUIRED_1;
      SYNC_ACQUIRED_3:
        state_d = cgbad ? SYNC_ACQUIRED_4
                        : SYNC_ACQUIRED_3A;
      SYNC_ACQUIRED_3A:
        if (cgbad)
          state_d = SYNC_ACQUIRED_4;
        else if (gc_q == GC_MAX)
          state_d = SYNC_ACQUIRED_2;
      SYNC_ACQUIRED_4:
        state_d = cgbad ? LOSS_OF_SYNC
                        : SYNC_ACQUIRED_4A;
      SYNC_ACQUIRED_4A:
        if (cgbad)
          state_d = LOSS_OF_SYNC;
        else if (gc_q == GC_MAX)
          state_d = SYNC_ACQUIRED_3;
      default:
        state_d = LOSS_OF_SYNC;
    endcase
    if (|(state_d & SAN_MASK))
      gc_d = 2'd0;
    else if (|(state_d & SANA_MASK))
      gc_d = (gc_q == 2'd3) ? 2'd3 : gc_q + 2'd1;
  end

  // Entry actions of the destination state
  assign rx_even_d = (|(state_d & CD_MASK)) | ~rx_even_q;
  assign sync_d    = |(state_d & SA_MASK);

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOSS_OF_SYNC;
      gc_q      <= 2'd0;
      x_q       <= 10'd0;
      sudi_q    <= 1'b0;
      rx_even_q <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gc_q      <= gc_d;
      x_q       <= code_group;
      sudi_q    <= 1'b1;
      rx_even_q <= rx_even_d;
      sync_q    <= sync_d;
    end
  end

  assign x           = x_q;
  assign SUDI        = sudi_q;
  assign rx_even     = rx_even_q;
  assign sync_status = sync_q;

endmodule

// File: tb/tb_pcs_sync.sv
// Directed bench for pcs_sync: acquisition, loss, odd commas,
// classifier spot checks and asynchronous reset.
module tb_pcs_sync;
  import pcs_sync_pkg::*;

  localparam logic [9:0] KN   = 10'h0FA;
  localparam logic [9:0] KP   = 10'h305;
  localparam logic [9:0] DN   = 10'h1B5;
  localparam logic [9:0] DP   = 10'h245;
  localparam logic [9:0] K277 = 10'h368;
  localparam logic [9:0] BAD  = 10'h000;

  logic       clk;
  logic       rst;
  logic [9:0] code_group;
  logic [9:0] x;
  logic       SUDI;
  logic       rx_even;
  logic       sync_status;

  int checks   = 0;
  int failures = 0;

  pcs_sync dut (
    .clk         (clk),
    .rst         (rst),
    .code_group  (code_group),
    .x           (x),
    .SUDI        (SUDI),
    .rx_even     (rx_even),
    .sync_status (sync_status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input logic [31:0] got,
    input logic [31:0] exp,
    input string       what
  );
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got %h exp %h", what, got, exp);
    end
  endtask

  task automatic step(
    input logic [9:0] cg,
    input logic       ev,
    input logic       es,
    input state_e     st,
    input string      tag
  );
    code_group = cg;
    @(posedge clk);
    #1;
    chk(32'(x), 32'(cg), {tag, ".x"});
    chk(32'(SUDI), 32'd1, {tag, ".SUDI"});
    chk(32'(rx_even), 32'(ev), {tag, ".rx_even"});
    chk(32'(sync_status), 32'(es), {tag, ".sync"});
    chk(32'(dut.state_q), 32'(st), {tag, ".state"});
  endtask

  task automatic cls(
    input logic [9:0] cg,
    input logic       v,
    input logic       d,
    input logic       c,
    input string      tag
  );
    code_group = cg;
    #1;
    chk(32'(dut.u_cls.is_valid), 32'(v), {tag, ".valid"});
    chk(32'(dut.u_cls.is_data), 32'(d), {tag, ".data"});
    chk(32'(dut.u_cls.is_comma), 32'(c), {tag, ".comma"});
  endtask

  task automatic all_zero(input string tag);
    chk(32'(x), 32'd0, {tag, ".x"});
    chk(32'(SUDI), 32'd0, {tag, ".SUDI"});
    chk(32'(rx_even), 32'd0, {tag, ".rx_even"});
    chk(32'(sync_status), 32'd0, {tag, ".sync"});
    chk(32'(dut.state_q), 32'(LOSS_OF_SYNC),
        {tag, ".state"});
  endtask

  task automatic acquire(input string t);
    step(KN, 1, 0, COMMA_DETECT_1, {t, "0"});
    step(DP, 0, 0, ACQUIRE_SYNC_1, {t, "1"});
    step(KP, 1, 0, COMMA_DETECT_2, {t, "2"});
    step(DN, 0, 0, ACQUIRE_SYNC_2, {t, "3"});
    step(KN, 1, 0, COMMA_DETECT_3, {t, "4"});
    step(DP, 0, 1, SYNC_ACQUIRED_1, {t, "5"});
    step(KP, 1, 1, SYNC_ACQUIRED_1, {t, "6"});
    step(DN, 0, 1, SYNC_ACQUIRED_1, {t, "7"});
  endtask

  initial begin
    rst        = 1'b0;
    code_group = 10'd0;
    #1 rst = 1'b1;
    #1;
    all_zero("rst");
    chk(32'(dut.gc_q), 32'd0, "rst.gc");

    cls(10'h0FA, 1, 0, 1, "c_k285n");
    cls(10'h305, 1, 0, 1, "c_k285p");
    cls(10'h1B5, 1, 1, 0, "c_d162n");
    cls(10'h245, 1, 1, 0, "c_d162p");
    cls(10'h368, 1, 0, 0, "c_k277");
    cls(10'h0F9, 1, 0, 0, "c_k281");
    cls(10'h274, 1, 1, 0, "c_d000");
    cls(10'h2AA, 1, 1, 0, "c_d215");
    cls(10'h237, 1, 1, 0, "c_d177a");
    cls(10'h23E, 0, 0, 0, "c_d177p");
    cls(10'h000, 0, 0, 0, "c_zero");
    cls(10'h3FF, 0, 0, 0, "c_ones");

    code_group = 10'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(32'(SUDI), 32'd0, "rel.SUDI");

    acquire("s1_");

    step(BAD, 1, 1, SYNC_ACQUIRED_2,  "s2_0");
    step(DP,  0, 1, SYNC_ACQUIRED_2A, "s2_1");
    step(KN,  1, 1, SYNC_ACQUIRED_2A, "s2_2");
    step(DN,  0, 1, SYNC_ACQUIRED_2A, "s2_3");
    step(KP,  1, 1, SYNC_ACQUIRED_1,  "s2_4");

    step(DP,  0, 1, SYNC_ACQUIRED_1,  "b_0");
    step(BAD, 1, 1, SYNC_ACQUIRED_2,  "b_1");
    step(DN,  0, 1, SYNC_ACQUIRED_2A, "b_2");
    step(KP,  1, 1, SYNC_ACQUIRED_2A, "b_3");
    step(DP,  0, 1, SYNC_ACQUIRED_2A, "b_4");
    chk(32'(dut.gc_q), 32'd3, "b_4.gc");
    step(BAD, 1, 1, SYNC_ACQUIRED_3,  "b_5");
    step(DN,  0, 1, SYNC_ACQUIRED_3A, "b_6");
    step(KN,  1, 1, SYNC_ACQUIRED_3A, "b_7");
    step(DP,  0, 1, SYNC_ACQUIRED_3A, "b_8");
    step(KP,  1, 1, SYNC_ACQUIRED_2,  "b_9");
    step(DN,  0, 1, SYNC_ACQUIRED_2A, "b_10");
    step(KN,  1, 1, SYNC_ACQUIRED_2A, "b_11");
    step(DP,  0, 1, SYNC_ACQUIRED_2A, "b_12");
    step(KP,  1, 1, SYNC_ACQUIRED_1,  "b_13");

    step(DN,  0, 1, SYNC_ACQUIRED_1,  "s3_0");
    step(BAD, 1, 1, SYNC_ACQUIRED_2,  "s3_1");
    step(DP,  0, 1, SYNC_ACQUIRED_2A, "s3_2");
    step(KN,  1, 1, SYNC_ACQUIRED_2A, "s3_3");
    step(BAD, 0, 1, SYNC_ACQUIRED_3,  "s3_4");
    step(KP,  1, 1, SYNC_ACQUIRED_3A, "s3_5");
    step(DN,  0, 1, SYNC_ACQUIRED_3A, "s3_6");
    step(BAD, 1, 1, SYNC_ACQUIRED_4,  "s3_7");
    step(DP,  0, 1, SYNC_ACQUIRED_4A, "s3_8");
    step(BAD, 1, 0, LOSS_OF_SYNC,     "s3_9");

    acquire("s4a_");
    step(DP, 1, 1, SYNC_ACQUIRED_1,  "s4_0");
    step(KN, 0, 1, SYNC_ACQUIRED_2,  "s4_1");
    step(DN, 1, 1, SYNC_ACQUIRED_2A, "s4_2");
    step(KP, 0, 1, SYNC_ACQUIRED_3,  "s4_3");
    step(DP, 1, 1, SYNC_ACQUIRED_3A, "s4_4");
    step(KN, 0, 1, SYNC_ACQUIRED_4,  "s4_5");
    step(DN, 1, 1, SYNC_ACQUIRED_4A, "s4_6");
    step(KP, 0, 0, LOSS_OF_SYNC,     "s4_7");

    step(KN,   1, 0, COMMA_DETECT_1, "s5_0");
    step(K277, 0, 0, LOSS_OF_SYNC,   "s5_1");
    step(DP,   1, 0, LOSS_OF_SYNC,   "s5_2");
    step(KP,   1, 0, COMMA_DETECT_1, "s5_3");
    step(KN,   0, 0, LOSS_OF_SYNC,   "s5_4");
    step(KN,   1, 0, COMMA_DETECT_1, "s5_5");
    step(DN,   0, 0, ACQUIRE_SYNC_1, "s5_6");
    step(BAD,  1, 0, LOSS_OF_SYNC,   "s5_7");
    step(KP,   1, 0, COMMA_DETECT_1, "s5_8");
    step(DP,   0, 0, ACQUIRE_SYNC_1, "s5_9");
    step(DN,   1, 0, ACQUIRE_SYNC_1, "s5_10");
    step(KN,   0, 0, LOSS_OF_SYNC,   "s5_11");

    acquire("s6a_");
    code_group = KN;
    #3 rst = 1'b1;
    #1;
    all_zero("s6_rst");
    @(posedge clk);
    #1;
    all_zero("s6_hold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(32'(SUDI), 32'd0, "s6_rel.SUDI");
    acquire("s6b_");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
